// File: rtl/stream_mux_pkg.sv
// Shared types and elaboration helpers for the stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // True when the parameter set is usable: at least two channels and a sel
  // wide enough to address every channel.
  function automatic bit sel_w_ok(input int n_ch, input int sel_w);
    return (n_ch >= 2) && ((1 << sel_w) >= n_ch);
  endfunction

endpackage

// File: rtl/stream_mux_sel_reg_slice.sv
// Single-entry registered valid/ready stage. It can accept a new word in
// the same cycle that the held word drains.
module stream_reg_slice #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] data_q;
  logic         valid_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_valid = valid_q;

  // Load on accept, drop valid on drain, otherwise hold the word unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      data_q  <= in_data;
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_mux_sel.sv
// N-channel packet multiplexer. The channel is picked from sel while idle
// and stays locked until the beat that carries in_last is accepted.
module stream_mux_sel
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 6,
  parameter int WIDTH = 4,
  parameter int SEL_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  busy,
  output logic                  sel_err,
  input  logic                  err_clr,
  output logic [CNT_W-1:0]      pkt_cnt
);

  if (!sel_w_ok(N_CH, SEL_W)) begin : g_bad_params
    $error("stream_mux_sel: need N_CH >= 2 and 2**SEL_W >= N_CH");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             sel_err_q, sel_err_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             busy_q;

  logic [WIDTH-1:0] mux_data;
  logic             mux_valid;
  logic             mux_last;
  logic             slice_ready;
  logic             accept;
  logic             sel_ok;

  // Extra top bit keeps the compare exact when N_CH == 2**SEL_W.
  assign sel_ok = ({1'b0, sel} < (SEL_W + 1)'(N_CH));

  // Route the locked channel to the output stage; nothing flows while idle.
  always_comb begin
    mux_data  = '0;
    mux_valid = 1'b0;
    mux_last  = 1'b0;
    in_ready  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cur_sel_q == SEL_W'(i)) begin
        mux_data  = in_data[i*WIDTH +: WIDTH];
        mux_valid = in_valid[i] && (state_q == LOCKED);
        mux_last  = in_last[i];
        in_ready[i] = slice_ready && (state_q == LOCKED);
      end
    end
  end

  assign accept = mux_valid && slice_ready;

  // Next-state, channel lock, error flag and packet counter.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    sel_err_d = sel_err_q;
    pkt_cnt_d = pkt_cnt_q;
    if (err_clr) sel_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          cur_sel_d = sel;
          state_d   = LOCKED;
        end else begin
          sel_err_d = 1'b1;
        end
      end
      LOCKED: begin
        if (accept && mux_last) begin
          state_d   = IDLE;
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      sel_err_q <= 1'b0;
      pkt_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      sel_err_q <= sel_err_d;
      pkt_cnt_q <= pkt_cnt_d;
      busy_q    <= (state_d == LOCKED);
    end
  end

  stream_reg_slice #(
    .W (WIDTH + 1)
  ) u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   ({mux_last, mux_data}),
    .in_valid  (mux_valid),
    .in_ready  (slice_ready),
    .out_data  ({out_last, out_data}),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign cur_sel = cur_sel_q;
  assign busy    = busy_q;
  assign sel_err = sel_err_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule
